mult_batch_engine: RTL and testbench

Parametrised multiply sequencer that replaces the fixed ROM → register file → combinational multiplier → RAM datapath with one self-timed engine. On `start`, it streams `count` operand pairs from an external synchronous ROM and multiplies each pair with an internal shift-add multiplier. In element-wise mode it writes every product to an external RAM; in accumulate mode it writes a single dot-product. It sits between the program ROM and the result RAM, and `busy`/`done` are exposed for the top-level controller.

---
 rtl/mult_batch_pkg.sv | 20 ++
 rtl/mult_batch_engine_seq_mult.sv | 49 ++++
 rtl/mult_batch_engine.sv | 169 ++++++++++++++++
 tb/tb_mult_batch_engine.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_batch_pkg.sv
// Shared types for the batch multiply engine.
// FSM state encoding and run-mode constants.
package mult_batch_pkg;

    typedef enum logic [3:0] {
        IDLE,
        FETCH_A,
        FETCH_B,
        LOAD,
        MUL,
        WRITE,
        ACC,
        WRITE_ACC,
        DONE
    } state_t;

    localparam logic MODE_ELEM = 1'b0;
    localparam logic MODE_ACC  = 1'b1;

endpackage

// File: rtl/mult_batch_engine_seq_mult.sv
// Shift-add multiplier, one partial product per cycle.
// valid flags the final step; product is complete after that edge.
module seq_mult #(
    parameter int DW = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [DW-1:0]   a,
    input  logic [DW-1:0]   b,
    output logic [2*DW-1:0] product,
    output logic            valid
);

    localparam int CW = $clog2(DW + 1);

    logic [2*DW-1:0] a_sh;
    logic [DW-1:0]   b_sh;
    logic [CW-1:0]   step;
    logic            run;

    assign valid = run && (step == CW'(DW - 1));

    // Load operands, then add the shifted multiplicand for each set bit of b.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_sh    <= '0;
            b_sh    <= '0;
            step    <= '0;
            run     <= 1'b0;
            product <= '0;
        end else if (load) begin
            a_sh    <= (2*DW)'(a);
            b_sh    <= b;
            step    <= '0;
            run     <= 1'b1;
            product <= '0;
        end else if (run) begin
            if (b_sh[0])
                product <= product + a_sh;
            a_sh <= a_sh << 1;
            b_sh <= b_sh >> 1;
            step <= step + CW'(1);
            if (valid)
                run <= 1'b0;
        end
    end

endmodule

// File: rtl/mult_batch_engine.sv
// Batch multiply sequencer: ROM operand pairs in, products or dot product out.
// Strobes decode the registered state; ram_addr/ram_wdata hold between writes.
module mult_batch_engine
    import mult_batch_pkg::*;
#(
    parameter int DW   = 4,
    parameter int AW   = 8,
    parameter int ACCW = 12
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            mode,
    input  logic [AW-1:0]   src_base,
    input  logic [AW-1:0]   dst_base,
    input  logic [AW-1:0]   count,
    output logic            rom_en,
    output logic [AW-1:0]   rom_addr,
    input  logic [DW-1:0]   rom_data,
    output logic            ram_we,
    output logic [AW-1:0]   ram_addr,
    output logic [ACCW-1:0] ram_wdata,
    output logic            busy,
    output logic            done,
    output logic [ACCW-1:0] result,
    output logic            overflow
);

    state_t          state;
    logic [AW-1:0]   src_ptr;
    logic [AW-1:0]   dst_ptr;
    logic [AW-1:0]   dst_base_q;
    logic [AW-1:0]   rem_q;
    logic [AW-1:0]   ram_addr_q;
    logic [ACCW-1:0] ram_wdata_q;
    logic [ACCW-1:0] acc_q;
    logic [ACCW-1:0] prod_ext;
    logic [ACCW:0]   acc_sum;
    logic [DW-1:0]   a_q;
    logic            mode_q;
    logic [2*DW-1:0] product;
    logic            mul_valid;
    logic            mul_load;

    assign mul_load = (state == LOAD);
    assign prod_ext = ACCW'(product);
    assign acc_sum  = {1'b0, acc_q} + (ACCW+1)'(product);

    seq_mult #(.DW(DW)) u_mult (
        .clk     (clk),
        .rst     (rst),
        .load    (mul_load),
        .a       (a_q),
        .b       (rom_data),
        .product (product),
        .valid   (mul_valid)
    );

    // Memory strobes and addresses follow the current state.
    always_comb begin
        rom_en    = 1'b0;
        rom_addr  = src_ptr;
        ram_we    = 1'b0;
        ram_addr  = ram_addr_q;
        ram_wdata = ram_wdata_q;
        unique case (1'b1)
            state == FETCH_A: rom_en = 1'b1;
            state == FETCH_B: begin
                rom_en   = 1'b1;
                rom_addr = src_ptr + AW'(1);
            end
            state == WRITE: begin
                ram_we    = 1'b1;
                ram_addr  = dst_ptr;
                ram_wdata = prod_ext;
            end
            state == WRITE_ACC: begin
                ram_we    = 1'b1;
                ram_addr  = dst_base_q;
                ram_wdata = acc_q;
            end
            default: ;
        endcase
    end

    // Run control: latch the job, walk pairs, write or accumulate.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            src_ptr     <= '0;
            dst_ptr     <= '0;
            dst_base_q  <= '0;
            rem_q       <= '0;
            mode_q      <= MODE_ELEM;
            a_q         <= '0;
            acc_q       <= '0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
            overflow    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: if (start) begin
                    src_ptr    <= src_base;
                    dst_ptr    <= dst_base;
                    dst_base_q <= dst_base;
                    rem_q      <= count;
                    mode_q     <= mode;
                    acc_q      <= '0;
                    overflow   <= 1'b0;
                    busy       <= 1'b1;
                    if (count == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state <= FETCH_A;
                    end
                end
                FETCH_A: state <= FETCH_B;
                FETCH_B: begin
                    a_q   <= rom_data;
                    state <= LOAD;
                end
                LOAD: begin
                    src_ptr <= src_ptr + AW'(2);
                    state   <= MUL;
                end
                MUL: if (mul_valid)
                    state <= (mode_q == MODE_ACC) ? ACC : WRITE;
                WRITE: begin
                    result      <= prod_ext;
                    ram_addr_q  <= dst_ptr;
                    ram_wdata_q <= prod_ext;
                    dst_ptr     <= dst_ptr + AW'(1);
                    rem_q       <= rem_q - AW'(1);
                    if (rem_q == AW'(1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state <= FETCH_A;
                    end
                end
                ACC: begin
                    acc_q <= acc_sum[ACCW-1:0];
                    if (acc_sum[ACCW])
                        overflow <= 1'b1;
                    rem_q <= rem_q - AW'(1);
                    state <= (rem_q == AW'(1)) ? WRITE_ACC : FETCH_A;
                end
                WRITE_ACC: begin
                    result      <= acc_q;
                    ram_addr_q  <= dst_base_q;
                    ram_wdata_q <= acc_q;
                    state       <= DONE;
                    done        <= 1'b1;
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_batch_engine.sv
// Scoreboard bench for mult_batch_engine.
// Expected RAM writes are queued at launch and popped as the DUT writes.
module tb_mult_batch_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [7:0]  src_base = '0;
    logic [7:0]  dst_base = '0;
    logic [7:0]  count = '0;
    logic        rom_en;
    logic [7:0]  rom_addr;
    logic [3:0]  rom_data;
    logic        ram_we;
    logic [7:0]  ram_addr;
    logic [11:0] ram_wdata;
    logic        busy;
    logic        done;
    logic [11:0] result;
    logic        overflow;

    typedef struct {
        int          cyc;
        logic [7:0]  addr;
        logic [11:0] data;
    } wr_t;

    logic [3:0] rom [256];
    wr_t        exp_q[$];
    logic [7:0] rom_log[$];
    int         cyc = 0;
    int         t0 = 0;
    int         rd_cnt = 0;
    int         wr_cnt = 0;
    int         errors = 0;
    int         checks = 0;

    mult_batch_engine #(.DW(4), .AW(8), .ACCW(12)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .src_base  (src_base),
        .dst_base  (dst_base),
        .count     (count),
        .rom_en    (rom_en),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) if (rom_en) rom_data <= rom[rom_addr];

    task automatic monitor();
        wr_t e;
        int  rel;
        forever begin
            @(negedge clk);
            rel = cyc - t0;
            if (rom_en) begin
                rd_cnt++;
                rom_log.push_back(rom_addr);
            end
            if (ram_we) begin
                wr_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write addr=%0d data=%0d cycle=%0d",
                             ram_addr, ram_wdata, rel);
                end else begin
                    e = exp_q.pop_front();
                    if (ram_addr !== e.addr || ram_wdata !== e.data || rel != e.cyc) begin
                        errors++;
                        $display("FAIL ram_write got addr=%0d data=%0d cycle=%0d want addr=%0d data=%0d cycle=%0d",
                                 ram_addr, ram_wdata, rel, e.addr, e.data, e.cyc);
                    end
                end
            end
        end
    endtask

    task automatic push_elem(input logic [7:0] s, input logic [7:0] d, input int c);
        wr_t        e;
        logic [7:0] pa;
        for (int k = 0; k < c; k++) begin
            pa     = s + 8'(2 * k);
            e.addr = d + 8'(k);
            e.data = 12'(int'(rom[pa]) * int'(rom[pa + 8'd1]));
            e.cyc  = k * 8 + 8;
            exp_q.push_back(e);
        end
    endtask

    task automatic push_acc(input logic [7:0] s, input logic [7:0] d, input int c);
        wr_t        e;
        logic [7:0] pa;
        int         sum;
        sum = 0;
        for (int k = 0; k < c; k++) begin
            pa  = s + 8'(2 * k);
            sum = sum + int'(rom[pa]) * int'(rom[pa + 8'd1]);
        end
        e.addr = d;
        e.data = 12'(sum % 4096);
        e.cyc  = c * 8 + 1;
        exp_q.push_back(e);
    endtask

    task automatic run(input logic m, input logic [7:0] s, input logic [7:0] d,
                       input logic [7:0] c, input int poke, input int exp_done,
                       input string name);
        int drel;
        @(negedge clk);
        mode = m;
        src_base = s;
        dst_base = d;
        count = c;
        start = 1'b1;
        t0 = cyc;
        rd_cnt = 0;
        wr_cnt = 0;
        rom_log.delete();
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s_busy got=%b want=1", name, busy);
        end
        drel = -1;
        for (int i = 0; i < 400; i++) begin
            if (cyc - t0 == poke) begin
                start = 1'b1;
                mode = ~m;
                src_base = 8'd100;
                dst_base = 8'd200;
                count = 8'd9;
            end else begin
                start = 1'b0;
            end
            if (done === 1'b1) begin
                drel = cyc - t0;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (drel != exp_done) begin
            errors++;
            $display("FAIL %s_done_cycle got=%0d want=%0d", name, drel, exp_done);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_end got busy=%b pending=%0d want busy=0 pending=0",
                     name, busy, exp_q.size());
        end
    endtask

    task automatic check_zero(input string name);
        checks++;
        if ({rom_en, rom_addr, ram_we, ram_addr, ram_wdata, busy, done, result, overflow} !== '0) begin
            errors++;
            $display("FAIL %s got rom_en=%b rom_addr=%0d ram_we=%b ram_addr=%0d wdata=%0d busy=%b done=%b result=%0d ovf=%b want all 0",
                     name, rom_en, rom_addr, ram_we, ram_addr, ram_wdata, busy, done, result, overflow);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_zero("reset_outputs");
        rst = 1'b1;
        @(negedge clk);
        check_zero("after_release");
    endtask

    task automatic test_elementwise();
        rom[0] = 4'd3;
        rom[1] = 4'd5;
        rom[2] = 4'd15;
        rom[3] = 4'd15;
        push_elem(8'd0, 8'd16, 2);
        run(1'b0, 8'd0, 8'd16, 8'd2, -1, 17, "elem");
        checks++;
        if (result !== 12'd225 || overflow !== 1'b0 || wr_cnt != 2) begin
            errors++;
            $display("FAIL elem_result got result=%0d ovf=%b writes=%0d want 225 0 2",
                     result, overflow, wr_cnt);
        end
    endtask

    task automatic test_accumulate();
        for (int i = 0; i < 6; i++) rom[i] = 4'(i + 2);
        push_acc(8'd0, 8'd40, 3);
        run(1'b1, 8'd0, 8'd40, 8'd3, -1, 26, "acc");
        checks++;
        if (result !== 12'd68 || overflow !== 1'b0 || wr_cnt != 1) begin
            errors++;
            $display("FAIL acc_result got result=%0d ovf=%b writes=%0d want 68 0 1",
                     result, overflow, wr_cnt);
        end
    endtask

    task automatic test_empty();
        run(1'b0, 8'd0, 8'd16, 8'd0, -1, 1, "empty");
        checks++;
        if (rd_cnt != 0 || wr_cnt != 0) begin
            errors++;
            $display("FAIL empty_strobes got reads=%0d writes=%0d want 0 0", rd_cnt, wr_cnt);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 40; i++) rom[i] = 4'd15;
        push_acc(8'd0, 8'd60, 20);
        run(1'b1, 8'd0, 8'd60, 8'd20, -1, 162, "ovf");
        checks++;
        if (result !== 12'd404 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_result got result=%0d ovf=%b want 404 1", result, overflow);
        end
        push_elem(8'd0, 8'd5, 1);
        run(1'b0, 8'd0, 8'd5, 8'd1, -1, 9, "ovf_clear");
        checks++;
        if (overflow !== 1'b0 || result !== 12'd225) begin
            errors++;
            $display("FAIL ovf_clear got ovf=%b result=%0d want 0 225", overflow, result);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] want [4];
        logic       ok;
        rom[254] = 4'd3;
        rom[255] = 4'd4;
        rom[0]   = 4'd5;
        rom[1]   = 4'd6;
        want[0] = 8'd254;
        want[1] = 8'd255;
        want[2] = 8'd0;
        want[3] = 8'd1;
        push_elem(8'd254, 8'd255, 2);
        run(1'b0, 8'd254, 8'd255, 8'd2, -1, 17, "wrap");
        ok = (rom_log.size() == 4);
        if (ok)
            for (int i = 0; i < 4; i++) if (rom_log[i] !== want[i]) ok = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wrap_rom_reads got n=%0d first=%0d want 254,255,0,1",
                     rom_log.size(), rom_log.size() > 0 ? rom_log[0] : 8'd0);
        end
        checks++;
        if (result !== 12'd30) begin
            errors++;
            $display("FAIL wrap_result got=%0d want=30", result);
        end
    endtask

    task automatic test_reset_midrun();
        rom[0] = 4'd3;
        rom[1] = 4'd5;
        rom[2] = 4'd7;
        rom[3] = 4'd9;
        @(negedge clk);
        mode = 1'b0;
        src_base = 8'd0;
        dst_base = 8'd16;
        count = 8'd2;
        start = 1'b1;
        t0 = cyc;
        wr_cnt = 0;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        #1;
        check_zero("midrun_reset");
        @(negedge clk);
        rst = 1'b1;
        repeat (12) @(negedge clk);
        checks++;
        if (wr_cnt != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midrun_quiet got writes=%0d busy=%b want 0 0", wr_cnt, busy);
        end
        push_elem(8'd0, 8'd16, 2);
        run(1'b0, 8'd0, 8'd16, 8'd2, -1, 17, "post_reset");
        checks++;
        if (result !== 12'd63) begin
            errors++;
            $display("FAIL post_reset_result got=%0d want=63", result);
        end
    endtask

    task automatic test_start_while_busy();
        rom[0] = 4'd2;
        rom[1] = 4'd9;
        rom[2] = 4'd11;
        rom[3] = 4'd13;
        push_elem(8'd0, 8'd16, 2);
        run(1'b0, 8'd0, 8'd16, 8'd2, 5, 17, "busy_start");
        checks++;
        if (result !== 12'd143 || wr_cnt != 2) begin
            errors++;
            $display("FAIL busy_start_result got result=%0d writes=%0d want 143 2",
                     result, wr_cnt);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 4'd0;
        fork
            monitor();
        join_none
        test_reset();
        test_elementwise();
        test_accumulate();
        test_empty();
        test_overflow();
        test_wrap();
        test_reset_midrun();
        test_start_while_busy();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
